// File: rtl/led_cube_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : led_cube_pkg
//  Purpose : Shared constants and types for the LED cube frame loader:
//            packet sync byte, frame size, address width and the loader
//            state enumeration.
//  Ports   : (package - none)
//  Rev     : 1.0  initial release
// ============================================================================
package led_cube_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES = 64;
   localparam int         ADDR_W      = 6;

   // Index of the final payload byte in a frame.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      PENDING = 2'd3
   } loader_state_e;

endpackage : led_cube_pkg
`default_nettype wire

// File: rtl/led_cube_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module  : led_cube_frame_ram
//  Purpose : Double frame buffer, 2 banks x 64 x 8 bits. One synchronous
//            write port and one combinational read port, each with its own
//            bank select.
//  Ports   : clk      - write clock
//            wr_bank  - bank written
//            wr_addr  - write address within the bank
//            wr_data  - write data
//            wr_en    - write enable
//            rd_bank  - bank read
//            rd_addr  - read address within the bank
//            rd_data  - read data (combinational)
//  Rev     : 1.0  initial release
// ============================================================================
module led_cube_frame_ram
   import led_cube_pkg::*;
(
   input  logic              clk,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   // Bank select forms the MSB of the flat storage index.
   logic [7:0] mem_q [0:2*FRAME_BYTES-1];

   // Storage is intentionally not reset; readers gate it with frame_valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[{wr_bank, wr_addr}] <= wr_data;
      end
   end

   assign rd_data = mem_q[{rd_bank, rd_addr}];

endmodule : led_cube_frame_ram
`default_nettype wire

// File: rtl/led_cube_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module  : led_cube_frame_loader
//  Purpose : Receives framed packets from a host byte stream
//            (A5, 64 payload bytes, XOR checksum) into the back half of a
//            double buffer, and swaps it to the front on the next displayed
//            frame boundary so the cube driver never sees a torn frame.
//  Ports   : clk            - clock, all logic on rising edge
//            rst_n          - synchronous active-low reset
//            byte_valid     - host byte present
//            byte_data      - host byte
//            byte_ready     - loader can accept a byte (state decode only)
//            frame_boundary - end-of-displayed-frame pulse from the driver
//            rd_addr        - driver read address
//            rd_data        - front buffer byte (00 until first swap)
//            frame_valid    - a frame has been swapped in since reset
//            frame_swapped  - one-cycle pulse per buffer swap
//            err_pulse      - one-cycle pulse on checksum error or timeout
//  Rev     : 1.0  initial release
// ============================================================================
module led_cube_frame_loader
   import led_cube_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              frame_boundary,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              frame_valid,
   output logic              frame_swapped,
   output logic              err_pulse
);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        csum_q, csum_d;
   logic [15:0]       idle_q, idle_d;
   logic              front_sel_q, front_sel_d;
   logic              frame_valid_q, frame_valid_d;
   logic              frame_swapped_q, frame_swapped_d;
   logic              err_pulse_q, err_pulse_d;

   logic              accept;
   logic              wr_en;
   logic [15:0]       idle_inc;
   logic [7:0]        ram_rd_data;

   // Ready depends on registered state only, never on byte_valid.
   assign byte_ready = (state_q != PENDING);
   assign accept     = byte_valid & byte_ready;
   assign idle_inc   = idle_q + 16'd1;

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      csum_d          = csum_q;
      idle_d          = idle_q;
      front_sel_d     = front_sel_q;
      frame_valid_d   = frame_valid_q;
      frame_swapped_d = 1'b0;
      err_pulse_d     = 1'b0;
      wr_en           = 1'b0;

      case (state_q)
         HUNT: begin
            idle_d = 16'd0;
            if (accept && (byte_data == SYNC_BYTE)) begin
               state_d = PAYLOAD;
               idx_d   = '0;
               csum_d  = 8'h00;
            end
         end

         PAYLOAD: begin
            if (accept) begin
               wr_en  = 1'b1;
               csum_d = csum_q ^ byte_data;
               idx_d  = idx_q + 1'b1;   // wraps 63 -> 0 ready for next packet
               idle_d = 16'd0;
               if (idx_q == LAST_IDX) begin
                  state_d = CHECK;
               end
            end else begin
               idle_d = idle_inc;
               if (idle_inc == TIMEOUT_CYCLES) begin
                  state_d     = HUNT;
                  err_pulse_d = 1'b1;
                  idle_d      = 16'd0;
               end
            end
         end

         CHECK: begin
            if (accept) begin
               idle_d = 16'd0;
               if (byte_data == csum_q) begin
                  state_d = PENDING;
               end else begin
                  state_d     = HUNT;
                  err_pulse_d = 1'b1;
               end
            end else begin
               idle_d = idle_inc;
               if (idle_inc == TIMEOUT_CYCLES) begin
                  state_d     = HUNT;
                  err_pulse_d = 1'b1;
                  idle_d      = 16'd0;
               end
            end
         end

         PENDING: begin
            // A boundary coinciding with the checksum byte was seen while
            // still in CHECK, so only a later boundary reaches this swap.
            idle_d = 16'd0;
            if (frame_boundary) begin
               front_sel_d     = ~front_sel_q;
               frame_valid_d   = 1'b1;
               frame_swapped_d = 1'b1;
               state_d         = HUNT;
            end
         end

         default: begin
            state_d = HUNT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= HUNT;
         idx_q           <= '0;
         csum_q          <= 8'h00;
         idle_q          <= 16'd0;
         front_sel_q     <= 1'b0;
         frame_valid_q   <= 1'b0;
         frame_swapped_q <= 1'b0;
         err_pulse_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         csum_q          <= csum_d;
         idle_q          <= idle_d;
         front_sel_q     <= front_sel_d;
         frame_valid_q   <= frame_valid_d;
         frame_swapped_q <= frame_swapped_d;
         err_pulse_q     <= err_pulse_d;
      end
   end

   // Payload always lands in the bank the driver is not reading.
   led_cube_frame_ram u_frame_ram (
      .clk     (clk),
      .wr_bank (~front_sel_q),
      .wr_addr (idx_q),
      .wr_data (byte_data),
      .wr_en   (wr_en),
      .rd_bank (front_sel_q),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   assign rd_data       = frame_valid_q ? ram_rd_data : 8'h00;
   assign frame_valid   = frame_valid_q;
   assign frame_swapped = frame_swapped_q;
   assign err_pulse     = err_pulse_q;

endmodule : led_cube_frame_loader
`default_nettype wire

// File: tb/tb_led_cube_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_led_cube_frame_loader
//  Purpose : Self-checking bench for led_cube_frame_loader. A packet-level
//            reference model (staging array copied to a front array on swap)
//            is compared against the DUT every cycle, plus table-driven
//            packets and directed corner-case sequences.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_led_cube_frame_loader;

   localparam logic [15:0] T_OUT = 16'd10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       frame_boundary = 1'b0;
   logic [5:0] rd_addr = 6'd0;
   logic       byte_ready;
   logic [7:0] rd_data;
   logic       frame_valid;
   logic       frame_swapped;
   logic       err_pulse;

   led_cube_frame_loader #(.TIMEOUT_CYCLES(T_OUT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .byte_valid     (byte_valid),
      .byte_data      (byte_data),
      .byte_ready     (byte_ready),
      .frame_boundary (frame_boundary),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .frame_valid    (frame_valid),
      .frame_swapped  (frame_swapped),
      .err_pulse      (err_pulse)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_pos: -1 hunting for sync, 0..63 payload bytes received so far,
   // 64 waiting for checksum, 65 complete and waiting for a boundary.
   int         m_pos = -1;
   logic [7:0] m_sum = 8'h00;
   int         m_idle = 0;
   logic [7:0] m_stage [64];
   logic [7:0] m_front [64];
   bit         m_valid = 0, m_swp = 0, m_err = 0;
   bit         rand_mode = 0;

   task automatic m_step();
      bit acc;
      if (!rst_n) begin
         m_pos = -1; m_sum = 8'h00; m_idle = 0;
         m_valid = 0; m_swp = 0; m_err = 0;
         return;
      end
      m_swp = 0;
      m_err = 0;
      acc = byte_valid && (m_pos != 65);
      if (m_pos == -1) begin
         if (acc && byte_data == 8'hA5) begin
            m_pos = 0; m_sum = 8'h00; m_idle = 0;
         end
      end else if (m_pos <= 64) begin
         if (acc) begin
            m_idle = 0;
            if (m_pos < 64) begin
               m_stage[m_pos] = byte_data;
               m_sum = m_sum ^ byte_data;
               m_pos++;
            end else if (byte_data == m_sum) begin
               m_pos = 65;
            end else begin
               m_pos = -1; m_err = 1;
            end
         end else begin
            m_idle++;
            if (m_idle == int'(T_OUT)) begin
               m_pos = -1; m_err = 1; m_idle = 0;
            end
         end
      end else if (frame_boundary) begin
         m_front = m_stage;
         m_valid = 1; m_swp = 1; m_pos = -1;
      end
   endtask

   // One clock: model consumes the current inputs, then outputs are compared
   // 1 time unit after the edge.
   task automatic tick();
      if (rand_mode) begin
         frame_boundary = ($urandom_range(0, 5) == 0);
         rd_addr        = 6'($urandom_range(0, 63));
      end
      m_step();
      @(posedge clk);
      #1;
      check("m_byte_ready", 32'(byte_ready), 32'(m_pos != 65));
      check("m_frame_valid", 32'(frame_valid), 32'(m_valid));
      check("m_frame_swapped", 32'(frame_swapped), 32'(m_swp));
      check("m_err_pulse", 32'(err_pulse), 32'(m_err));
      check("m_rd_data", 32'(rd_data), m_valid ? 32'(m_front[rd_addr]) : 32'd0);
   endtask

   int gap_max = 0;

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      while (m_pos == 65 && guard < 300) begin
         tick();
         guard++;
      end
      if (m_pos == 65) begin
         check("ready_wait_timeout", 32'd0, 32'd1);
         return;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
      if (gap_max > 0) begin
         int g;
         g = ($urandom_range(0, 199) == 0) ? 12 : $urandom_range(0, gap_max);
         repeat (g) tick();
      end
   endtask

   // Sync, 64 bytes base + step*i, then checksum (corrupted if !good).
   // fb_on_csum raises frame_boundary in the checksum cycle.
   task automatic send_packet(input logic [7:0] base, input logic [7:0] step,
                              input bit good, input bit fb_on_csum);
      logic [7:0] s, v;
      s = 8'h00;
      send_byte(8'hA5);
      for (int i = 0; i < 64; i++) begin
         v = base + step * 8'(i);
         s = s ^ v;
         send_byte(v);
      end
      if (fb_on_csum) frame_boundary = 1'b1;
      send_byte(good ? s : (s ^ 8'h01));
      if (fb_on_csum) frame_boundary = 1'b0;
   endtask

   task automatic pulse_boundary();
      frame_boundary = 1'b1;
      tick();
      frame_boundary = 1'b0;
   endtask

   typedef struct {
      logic [7:0] base;
      logic [7:0] step;
      bit         good;
      logic [5:0] probe;
      logic [7:0] exp_rd;
      bit         exp_valid;
   } vec_t;

   vec_t vt [5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{base: 8'hFF, step: 8'h00, good: 1'b0, probe: 6'd5,  exp_rd: 8'h00, exp_valid: 1'b0};
      vt[1] = '{base: 8'h00, step: 8'h01, good: 1'b1, probe: 6'd5,  exp_rd: 8'h05, exp_valid: 1'b1};
      vt[2] = '{base: 8'hFF, step: 8'h00, good: 1'b0, probe: 6'd5,  exp_rd: 8'h05, exp_valid: 1'b1};
      vt[3] = '{base: 8'h10, step: 8'h02, good: 1'b1, probe: 6'd3,  exp_rd: 8'h16, exp_valid: 1'b1};
      vt[4] = '{base: 8'h80, step: 8'h00, good: 1'b1, probe: 6'd63, exp_rd: 8'h80, exp_valid: 1'b1};

      // ---- reset state ----
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_frame_valid", 32'(frame_valid), 32'd0);
      check("rst_swapped", 32'(frame_swapped), 32'd0);
      check("rst_err", 32'(err_pulse), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rel_byte_ready", 32'(byte_ready), 32'd1);

      // ---- table-driven packets ----
      for (int k = 0; k < 5; k++) begin
         send_packet(vt[k].base, vt[k].step, vt[k].good, 1'b0);
         check("tbl_err_after_csum", 32'(err_pulse), 32'(!vt[k].good));
         if (vt[k].good) begin
            check("tbl_ready_pending", 32'(byte_ready), 32'd0);
            pulse_boundary();
            check("tbl_swapped", 32'(frame_swapped), 32'd1);
            tick();
            check("tbl_swapped_1cyc", 32'(frame_swapped), 32'd0);
         end else begin
            check("tbl_ready_hunt", 32'(byte_ready), 32'd1);
            tick();
            check("tbl_err_1cyc", 32'(err_pulse), 32'd0);
         end
         rd_addr = vt[k].probe;
         #1;
         check("tbl_rd_data", 32'(rd_data), 32'(vt[k].exp_rd));
         check("tbl_frame_valid", 32'(frame_valid), 32'(vt[k].exp_valid));
      end

      // ---- boundary coinciding with checksum, then held in pending ----
      send_packet(8'h33, 8'h05, 1'b1, 1'b1);
      check("same_cyc_no_swap", 32'(frame_swapped), 32'd0);
      rd_addr = 6'd1;
      for (int i = 0; i < 4; i++) begin
         byte_valid = 1'b1;
         byte_data  = 8'hA5;
         tick();
         check("pending_not_ready", 32'(byte_ready), 32'd0);
         check("pending_old_front", 32'(rd_data), 32'h80);
      end
      byte_valid = 1'b0;
      pulse_boundary();
      check("pending_swap", 32'(frame_swapped), 32'd1);
      check("pending_ready_after", 32'(byte_ready), 32'd1);
      check("pending_new_front", 32'(rd_data), 32'h38);

      // ---- garbage before sync ----
      send_byte(8'h00);
      send_byte(8'h11);
      send_packet(8'h40, 8'h03, 1'b1, 1'b0);
      pulse_boundary();
      rd_addr = 6'd2;
      #1;
      check("garbage_rd_data", 32'(rd_data), 32'h46);

      // ---- idle timeout mid-packet ----
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("timeout_err", 32'(err_pulse), 32'(i == 10));
      end
      check("timeout_ready", 32'(byte_ready), 32'd1);
      send_packet(8'h20, 8'h01, 1'b1, 1'b0);
      pulse_boundary();
      rd_addr = 6'd10;
      #1;
      check("post_timeout_rd", 32'(rd_data), 32'h2A);

      // ---- reset during payload byte 30 ----
      send_byte(8'hA5);
      for (int i = 0; i < 30; i++) send_byte(8'(i));
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      rst_n      = 1'b0;
      tick();
      byte_valid = 1'b0;
      check("midrst_frame_valid", 32'(frame_valid), 32'd0);
      check("midrst_rd_data", 32'(rd_data), 32'd0);
      check("midrst_swapped", 32'(frame_swapped), 32'd0);
      check("midrst_err", 32'(err_pulse), 32'd0);
      rst_n = 1'b1;
      tick();
      check("midrst_ready", 32'(byte_ready), 32'd1);
      send_packet(8'h5A, 8'h07, 1'b1, 1'b0);
      pulse_boundary();
      rd_addr = 6'd4;
      #1;
      check("midrst_reload", 32'(rd_data), 32'h76);

      // ---- randomized packets against the model ----
      rand_mode = 1;
      gap_max   = 2;
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
         send_packet(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      end
      repeat (20) tick();
      rand_mode      = 0;
      gap_max        = 0;
      frame_boundary = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_led_cube_frame_loader
`default_nettype wire

// File: doc/led_cube_frame_loader.md
LED_CUBE_FRAME_LOADER -- requirements
Module: led_cube_frame_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, max idle clk cycles between accepted bytes inside a packet.
REQ-002 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port byte_valid  input  1  host byte present.
REQ-005 SHALL have port byte_data  input  8  host byte.
REQ-006 SHALL have port byte_ready  output  1  loader can accept a byte.
REQ-007 SHALL have port frame_boundary  input  1  one-cycle pulse from the cube driver at the end of a displayed frame.
REQ-008 SHALL have port rd_addr  input  6  driver row address.
REQ-009 SHALL have port rd_data  output  8  front-buffer byte at rd_addr.
REQ-010 SHALL have port frame_valid  output  1  at least one frame has been swapped in since reset.
REQ-011 SHALL have port frame_swapped  output  1  one-cycle pulse on every buffer swap.
REQ-012 SHALL have port err_pulse  output  1  one-cycle pulse on checksum failure or timeout.

Function
REQ-013 SHALL accept a byte only at a clock edge where byte_valid && byte_ready are both 1.
REQ-014 SHALL implement states HUNT, PAYLOAD, CHECK and PENDING.
REQ-015 In HUNT: byte_ready=1; accepted 8'hA5 -> PAYLOAD with byte index=0 and checksum=0; any other byte is dropped.
REQ-016 In PAYLOAD: accepted byte n SHALL be written to back buffer address n and XORed into the checksum; after byte 63 -> CHECK (index wraps 63->0 without overflow).
REQ-017 In CHECK: an accepted byte equal to the running checksum -> PENDING; a mismatching byte -> HUNT with err_pulse=1 on the next cycle.
REQ-018 In PENDING: byte_ready=0; on frame_boundary=1, front/back select SHALL toggle at that edge, frame_valid is set to 1, frame_swapped pulses, and the state returns to HUNT.
REQ-019 A frame_boundary in the same cycle that a checksum byte is accepted SHALL NOT swap; the swap waits for the next frame_boundary.
REQ-020 frame_boundary in HUNT, PAYLOAD or CHECK SHALL be ignored.
REQ-021 In PAYLOAD/CHECK an idle counter SHALL clear on each accepted byte and increment otherwise; on reaching TIMEOUT_CYCLES -> HUNT with err_pulse=1; the back buffer contents are don't-care.
REQ-022 rd_data SHALL be combinational from rd_addr on the front buffer (0-cycle latency), forced to 8'h00 while frame_valid=0.
REQ-023 Writes SHALL go only to the back buffer; the front buffer SHALL never change between swaps (no tearing).
REQ-024 byte_ready SHALL be a registered-state decode only (1 in HUNT, PAYLOAD and CHECK; 0 in PENDING) with no combinational path from byte_valid.

Reset
REQ-025 On rst_n=0 at a clock edge: state=HUNT, front select=0, index=0, checksum=0, idle counter=0, frame_valid=0, frame_swapped=0, err_pulse=0.
REQ-026 Reset mid-packet SHALL discard the packet; buffer RAM contents are not reset, and rd_data reads 8'h00 through REQ-022.
REQ-027 byte_ready SHALL read 1 in the first cycle after reset is released.

Structure
REQ-028 led_cube_pkg SHALL hold SYNC_BYTE=8'hA5, FRAME_BYTES=64 and the loader state enum typedef.
REQ-029 The double buffer SHALL be a sub-module led_cube_frame_ram: 2x64x8, one synchronous write port (bank, addr, data, we) and one combinational read port (bank, addr).
REQ-030 Total RTL SHALL be 120-400 lines, with no vendor primitives.

Verification
REQ-031 Send A5, bytes 00..3F and checksum 00, then pulse frame_boundary -> frame_swapped=1 for 1 cycle, frame_valid=1, rd_addr=6'd5 gives rd_data=8'h05.
REQ-032 Send A5, 64 x 8'hFF and checksum 8'h01 -> err_pulse=1 for 1 cycle, state HUNT, front buffer unchanged, frame_valid stays 0.
REQ-033 Send a complete good frame with no frame_boundary -> byte_ready=0 and further bytes are not accepted; after a frame_boundary pulse -> byte_ready=1 on the next cycle.
REQ-034 Send garbage 00, 11 then A5 and a good frame -> the garbage is dropped and the frame is loaded correctly.
REQ-035 With TIMEOUT_CYCLES=10: send A5 plus 3 bytes, then idle 10 cycles -> err_pulse=1 and HUNT; a following good frame loads correctly.
REQ-036 Assert rst_n=0 during PAYLOAD byte 30 -> all REQ-025 values hold, rd_data=8'h00 and byte_ready=1 after release.
